// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS31 constants, state type and prediction helper
//
// Purpose: constants common to the PRBS31 generator and checker
//   (x^31 + x^28 + 1), the checker state enum and the next-bit predictor.
// Ports: none (package).
package prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 27;
  localparam int TAP_B    = 30;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // hist[0] is the most recent bit; the next bit of a clean stream is
  // the XOR of the bits 28 and 31 positions back.
  function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// rtl/prbs_sat_counter.sv - saturating event counter with sticky saturation flag
//
// Purpose: counts inc pulses up to all-ones and holds there; sat is set on
//   reaching all-ones and stays set until clr or rst. clr has priority over inc.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   inc   in  count one event
//   clr   in  synchronous clear of count and sat
//   count out W-bit saturating count
//   sat   out sticky saturation flag
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
      sat   <= (count == (MAX - W'(1)));
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 receive checker
//
// Purpose: hunts for PRBS31 alignment on a serial bit stream, then free-runs
//   a local reference and counts bit errors. Too many errors in one window
//   drops lock and restarts the hunt.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous reset, active HIGH despite the name
//   din       in  received serial bit
//   din_valid in  din is sampled only when 1
//   clr_cnt   in  synchronous clear of err_count / err_sat
//   locked    out 1 while locked to the stream
//   err       out one-cycle pulse per detected bit error
//   err_count out saturating error count
//   err_sat   out sticky, err_count reached all-ones
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_LEN   = 256,
  parameter int ERR_LIMIT = 8,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat
);

  localparam int FILL_W  = $clog2(PRBS_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN);
  localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PRBS_LEN);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  WERR_MAX  = WERR_W'(ERR_LIMIT);

  state_t              state, state_n;
  logic [PRBS_LEN-1:0] hist, hist_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [MATCH_W-1:0]  match, match_n;
  logic [WIN_W-1:0]    win, win_n;
  logic [WERR_W-1:0]   werr, werr_n;
  logic [WERR_W-1:0]   werr_sum;
  logic                err_n;
  logic                pred;
  logic                mism;

  assign pred     = prbs_pred(hist);
  assign mism     = din ^ pred;
  assign werr_sum = werr + WERR_W'(mism);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= HUNT;
      hist  <= '0;
      fill  <= '0;
      match <= '0;
      win   <= '0;
      werr  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      match <= match_n;
      win   <= win_n;
      werr  <= werr_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    match_n = match;
    win_n   = win;
    werr_n  = werr;
    err_n   = 1'b0;

    if (din_valid) begin
      case (state)
        HUNT: begin
          hist_n = {hist[PRBS_LEN-2:0], din};
          if (fill != FILL_FULL) begin
            fill_n = fill + FILL_W'(1);
          end else if (mism) begin
            match_n = '0;
          end else begin
            if (match != MATCH_MAX) begin
              match_n = match + MATCH_W'(1);
            end
            // An all-zero history satisfies the recurrence trivially, so
            // lock is held off until a one has been seen in the window.
            if ((match_n == MATCH_MAX) && (hist_n != '0)) begin
              state_n = LOCKED;
            end
          end
        end

        LOCKED: begin
          // Shift in the prediction, not din, so a corrupted input bit
          // never pollutes the reference.
          hist_n = {hist[PRBS_LEN-2:0], pred};
          err_n  = mism;
          if (werr_sum == WERR_MAX) begin
            state_n = HUNT;
            hist_n  = '0;
            fill_n  = '0;
            match_n = '0;
            win_n   = '0;
            werr_n  = '0;
          end else if (win == WIN_LAST) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win + WIN_W'(1);
            werr_n = werr_sum;
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  prbs_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst_n),
    .inc  (err_n),
    .clr  (clr_cnt),
    .count(err_count),
    .sat  (err_sat)
  );

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - self-checking bench for prbs31_checker
module tb_prbs31_checker;

  localparam int T_LOCK = 64;
  localparam int T_WIN  = 256;
  localparam int T_LIM  = 8;
  localparam int MAXC   = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0, din_valid = 1'b0, clr_cnt = 1'b0;
  logic locked, err, err_sat;
  logic [15:0] err_count;
  logic din_b = 1'b0, din_valid_b = 1'b0, clr_b = 1'b0;
  logic locked_b, err_b, err_sat_b;
  logic [3:0] err_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs31_checker #(.LOCK_CNT(T_LOCK), .WIN_LEN(T_WIN), .ERR_LIMIT(T_LIM), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_count(err_count), .err_sat(err_sat)
  );

  prbs31_checker #(.LOCK_CNT(T_LOCK), .WIN_LEN(T_WIN), .ERR_LIMIT(T_WIN), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b), .clr_cnt(clr_b),
    .locked(locked_b), .err(err_b), .err_count(err_count_b), .err_sat(err_sat_b)
  );

  logic [18:0] obs_a;
  logic [6:0]  obs_b;
  assign obs_a = {locked, err, err_count, err_sat};
  assign obs_b = {locked_b, err_b, err_count_b, err_sat_b};

  // Generator: bit n = bit(n-28) XOR bit(n-31), seeded with a single one.
  bit gseq[$];
  function automatic bit gen_next();
    int n = gseq.size();
    bit b;
    if (n < 31) b = (n == 0);
    else        b = gseq[n-28] ^ gseq[n-31];
    gseq.push_back(b);
    return b;
  endfunction

  // Reference model: seg holds the effective bit sequence since the last hunt
  // start (received bits while hunting, predicted bits once locked).
  bit seg[$];
  int run, last_one, lpos, werr, m_cnt;
  bit m_locked, m_err, m_sat;

  function automatic void model_reset();
    seg.delete();
    run = 0; last_one = -1000; lpos = 0; werr = 0; m_cnt = 0;
    m_locked = 0; m_err = 0; m_sat = 0;
  endfunction

  function automatic void model_step(bit d, bit v, bit c);
    int n = seg.size();
    bit p;
    p = (n >= 31) ? (seg[n-28] ^ seg[n-31]) : 1'b0;
    m_err = 0;
    if (v) begin
      if (!m_locked) begin
        seg.push_back(d);
        if (d) last_one = n;
        if (n >= 31) begin
          run = (d == p) ? run + 1 : 0;
          if (run >= T_LOCK && (n - last_one) < 31) begin
            m_locked = 1; lpos = 0; werr = 0;
          end
        end
      end else begin
        seg.push_back(p);
        if (p) last_one = n;
        if (d != p) begin
          m_err = 1;
          werr++;
          if (m_cnt < MAXC) m_cnt++;
        end
        if (werr >= T_LIM) begin
          m_locked = 0; seg.delete(); run = 0; last_one = -1000; lpos = 0; werr = 0;
        end else begin
          lpos++;
          if (lpos == T_WIN) begin lpos = 0; werr = 0; end
        end
      end
    end
    if (c) m_cnt = 0;
    m_sat = (m_cnt == MAXC);
  endfunction

  function automatic logic [18:0] exp_a();
    return {m_locked, m_err, 16'(m_cnt), m_sat};
  endfunction

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic cyc_a(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clr_cnt = c;
    model_step(d, v, c);
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input bit d, input bit v, input bit c);
    din_b = d; din_valid_b = v; clr_b = c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b1;
    #1;
    checks++; if (obs_a !== 19'd0) begin errors++; $display("FAIL reset_a: got %h want 0", obs_a); end
    checks++; if (obs_b !== 7'd0) begin errors++; $display("FAIL reset_b: got %h want 0", obs_b); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_lock();
    int lock_at = 0, err_seen = 0;
    do_reset();
    for (int i = 1; i <= 10000; i++) begin
      cyc_a(gen_next(), 1'b1, 1'b0);
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL clean bit %0d: got %h want %h", i, obs_a, exp_a()); end
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
      if (err !== 1'b0) err_seen++;
    end
    checks++; if (lock_at !== 95) begin errors++; $display("FAIL clean_lock_bit: got %0d want 95", lock_at); end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL clean_err_pulses: got %0d want 0", err_seen); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_single_error();
    do_reset();
    for (int i = 0; i < 115; i++) begin
      cyc_a(gen_next(), 1'b1, 1'b0);
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL single_pre %0d: got %h want %h", i, obs_a, exp_a()); end
    end
    cyc_a(~gen_next(), 1'b1, 1'b0);
    checks++; if ({locked, err, err_count} !== {1'b1, 1'b1, 16'd1}) begin errors++; $display("FAIL single_hit: got l=%0b e=%0b c=%0d want l=1 e=1 c=1", locked, err, err_count); end
    for (int i = 0; i < 50; i++) begin
      cyc_a(gen_next(), 1'b1, 1'b0);
      checks++; if (obs_a !== exp_a() || err !== 1'b0) begin errors++; $display("FAIL single_post %0d: got %h want %h", i, obs_a, exp_a()); end
    end
    checks++; if ({locked, err_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL single_end: got l=%0b c=%0d want l=1 c=1", locked, err_count); end
  endtask

  task automatic test_burst_unlock();
    int nb = 0;
    do_reset();
    for (int i = 0; i < 95; i++) cyc_a(gen_next(), 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 9; j++) begin
        cyc_a(gen_next(), 1'b1, 1'b0);
        checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL burst_clean k%0d: got %h want %h", k, obs_a, exp_a()); end
      end
      cyc_a(~gen_next(), 1'b1, 1'b0);
      checks++; if (locked !== (k < 8) || err !== 1'b1) begin errors++; $display("FAIL burst_err %0d: got l=%0b e=%0b want l=%0b e=1", k, locked, err, k < 8); end
    end
    checks++; if (err_count !== 16'd8) begin errors++; $display("FAIL burst_count: got %0d want 8", err_count); end
    while (locked !== 1'b1 && nb < 300) begin
      cyc_a(gen_next(), 1'b1, 1'b0);
      nb++;
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL relock %0d: got %h want %h", nb, obs_a, exp_a()); end
    end
    checks++; if (nb !== 95) begin errors++; $display("FAIL relock_bits: got %0d want 95", nb); end
  endtask

  task automatic test_zeros();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc_a(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL zeros_locked: got %0d locked cycles want 0", seen); end
  endtask

  task automatic test_valid_toggle();
    int vcount = 0, lockv = 0;
    bit v;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      v = (i % 2 == 0);
      cyc_a(v ? gen_next() : 1'($urandom_range(1, 0)), v, 1'b0);
      if (v) vcount++;
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL toggle %0d: got %h want %h", i, obs_a, exp_a()); end
      if (locked === 1'b1 && lockv == 0) lockv = vcount;
    end
    checks++; if (lockv !== 95) begin errors++; $display("FAIL toggle_lock_bits: got %0d want 95", lockv); end
  endtask

  task automatic test_random();
    int rate;
    bit v, e, c;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rate = ((i / 500) % 2 == 0) ? 400 : 12;
      v = ($urandom_range(3, 0) != 0);
      e = ($urandom_range(rate - 1, 0) == 0);
      c = ($urandom_range(299, 0) == 0);
      cyc_a(v ? (gen_next() ^ e) : 1'($urandom_range(1, 0)), v, c);
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL random %0d: got %h want %h", i, obs_a, exp_a()); end
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int i = 0; i < 95; i++) cyc_b(gen_next(), 1'b1, 1'b0);
    checks++; if (locked_b !== 1'b1) begin errors++; $display("FAIL sat_lock: got %0b want 1", locked_b); end
    for (int k = 1; k <= 20; k++) begin
      for (int j = 0; j < 9; j++) cyc_b(gen_next(), 1'b1, 1'b0);
      cyc_b(~gen_next(), 1'b1, 1'b0);
      want = (k < 15) ? k : 15;
      checks++; if (obs_b !== {1'b1, 1'b1, 4'(want), (k >= 15)}) begin errors++; $display("FAIL sat_err %0d: got %b want %b", k, obs_b, {1'b1, 1'b1, 4'(want), (k >= 15)}); end
    end
  endtask

  task automatic test_clr_with_err();
    cyc_b(~gen_next(), 1'b1, 1'b1);
    checks++; if (obs_b !== 7'b1100000) begin errors++; $display("FAIL clr_err: got %b want 1100000", obs_b); end
    cyc_b(~gen_next(), 1'b1, 1'b0);
    checks++; if (obs_b !== 7'b1100010) begin errors++; $display("FAIL clr_next: got %b want 1100010", obs_b); end
  endtask

  task automatic test_async_reset();
    int lock_at = 0;
    do_reset();
    for (int i = 0; i < 100; i++) cyc_a(~gen_next(), 1'b1, 1'b0);
    for (int i = 0; i < 140; i++) cyc_a(gen_next(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(~gen_next(), 1'b1, 1'b0);
    checks++; if (locked !== 1'b1 || err_count === 16'd0) begin errors++; $display("FAIL areset_pre: got l=%0b c=%0d want l=1 c>0", locked, err_count); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (obs_a !== 19'd0) begin errors++; $display("FAIL areset_a: got %h want 0", obs_a); end
    checks++; if (obs_b !== 7'd0) begin errors++; $display("FAIL areset_b: got %b want 0", obs_b); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    for (int i = 1; i <= 120; i++) begin
      cyc_a(gen_next(), 1'b1, 1'b0);
      checks++; if (obs_a !== exp_a()) begin errors++; $display("FAIL areset_post %0d: got %h want %h", i, obs_a, exp_a()); end
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    checks++; if (lock_at !== 95) begin errors++; $display("FAIL areset_relock: got %0d want 95", lock_at); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_burst_unlock();
    test_zeros();
    test_valid_toggle();
    test_random();
    test_saturation();
    test_clr_with_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
